pc_redirect_unit: RTL

- Program-counter generator for the fetch stage of the MIPS core.
- Holds the PC register, advances it by 4 each cycle, and applies redirects resolved in the execute stage: conditional branch, J/JAL, JR/JALR.
- Computes branch and jump targets internally from the redirecting instruction.
- Registers a pending redirect, flags misaligned register targets, and parks in an error state until reset.

---
 rtl/pc_redirect_unit.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// Fetch PC generator: sequential +4 advance with branch/J/JR redirects resolved in execute.
// Latency: redirect target appears on pc_o one cycle after the request (after the delay slot when DELAY_SLOT_EN is defined).
// Backpressure: stall_i holds the sequential advance; a redirect overrides the stall; misaligned JR parks the unit until rst.
module pc_redirect_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              br_req_i,
    input  logic              br_taken_i,
    input  logic              j_req_i,
    input  logic              jr_req_i,
    input  logic [31:0]       ex_instr_i,
    input  logic [ADDR_W-1:0] ex_pc_i,
    input  logic [ADDR_W-1:0] jr_target_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus4_o,
    output logic              fetch_valid_o,
    output logic              flush_o,
    output logic              misalign_o
);

    typedef enum logic {RUN, HALT} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              misalign, misalign_nxt;
    logic              flush;

    logic [ADDR_W-1:0] seq_pc, br_target, j_target, target;
    logic              redir_any, bad_jr;
    logic              unused_opcode;

`ifdef DELAY_SLOT_EN
    // Pending redirect: target waits until the delay-slot advance has happened.
    logic              pend_vld, pend_vld_nxt;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_nxt;
    logic              slot_done, slot_done_nxt;
`endif

    // Opcode/funct bits are decoded upstream; only offsets and indices matter here.
    assign unused_opcode = ^ex_instr_i[31:26];

    // Target arithmetic; carries out of ADDR_W are dropped by the adder width.
    always_comb begin
        seq_pc    = ex_pc_i + ADDR_W'(4);
        br_target = seq_pc + {{(ADDR_W-18){ex_instr_i[15]}}, ex_instr_i[15:0], 2'b00};
        j_target  = {seq_pc[ADDR_W-1:28], ex_instr_i[25:0], 2'b00};
        redir_any = jr_req_i | j_req_i | (br_req_i & br_taken_i);
        bad_jr    = jr_req_i & (jr_target_i[1:0] != 2'b00);
        if (jr_req_i)     target = jr_target_i;
        else if (j_req_i) target = j_target;
        else              target = br_target;
    end

    // Next-state, next-PC and flush decision.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        misalign_nxt = misalign;
        flush        = 1'b0;
`ifdef DELAY_SLOT_EN
        pend_vld_nxt  = pend_vld;
        pend_tgt_nxt  = pend_tgt;
        slot_done_nxt = slot_done;
`endif
        case (state)
            RUN: begin
`ifdef DELAY_SLOT_EN
                if (pend_vld) begin
                    // Requests arriving while a redirect is pending are dropped.
                    if (!stall_i) begin
                        if (slot_done) begin
                            pc_nxt       = pend_tgt;
                            pend_vld_nxt = 1'b0;
                        end else begin
                            pc_nxt        = pc + ADDR_W'(4);
                            slot_done_nxt = 1'b1;
                        end
                    end
                end else if (bad_jr) begin
                    state_nxt    = HALT;
                    misalign_nxt = 1'b1;
                end else if (redir_any) begin
                    pend_vld_nxt  = 1'b1;
                    pend_tgt_nxt  = target;
                    slot_done_nxt = !stall_i;
                    if (!stall_i) pc_nxt = pc + ADDR_W'(4);
                end else if (!stall_i) begin
                    pc_nxt = pc + ADDR_W'(4);
                end
`else
                if (bad_jr) begin
                    state_nxt    = HALT;
                    misalign_nxt = 1'b1;
                end else if (redir_any) begin
                    pc_nxt = target;
                    flush  = 1'b1;
                end else if (!stall_i) begin
                    pc_nxt = pc + ADDR_W'(4);
                end
`endif
            end
            default: begin
                // HALT: frozen until reset.
            end
        endcase
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            misalign <= 1'b0;
`ifdef DELAY_SLOT_EN
            pend_vld  <= 1'b0;
            pend_tgt  <= '0;
            slot_done <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            misalign <= misalign_nxt;
`ifdef DELAY_SLOT_EN
            pend_vld  <= pend_vld_nxt;
            pend_tgt  <= pend_tgt_nxt;
            slot_done <= slot_done_nxt;
`endif
        end
    end

    assign pc_o          = pc;
    assign pc_plus4_o    = pc + ADDR_W'(4);
    assign fetch_valid_o = (state == RUN);
    assign flush_o       = flush & ~rst;
    assign misalign_o    = misalign;

endmodule
